// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and a future receiver).
//   tx_state_t    : serialiser FSM states
//   PARITY_EVEN/ODD: encodings of the parity_type input
//   frame_cycles(): clocks per frame, for benches and higher-level models
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Frame length in clk cycles; a prescale of 0 behaves like 1.
  function automatic int frame_cycles(input int data_width, input bit parity_en,
                                      input bit two_stop, input int prescale);
    int p;
    p = (prescale < 1) ? 1 : prescale;
    return (2 + data_width + int'(parity_en) + int'(two_stop)) * p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   i_wr_en    : write request; ignored while full
//   i_wr_data  : data to enqueue
//   i_rd_en    : pop request; ignored while empty
//   o_rd_data  : head entry (valid whenever o_count != 0)
//   o_count    : occupied entries, registered
//   o_not_full : o_count < FIFO_DEPTH, derived from the registered count only
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wr_en,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic                          i_rd_en,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_not_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_not_full = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push     = i_wr_en && o_not_full;
  assign w_pop      = i_rd_en && (r_count != '0);

  // The head is read combinationally so the consumer can latch it on the
  // same edge that pops it.
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage carries no reset: stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_transmitter.sv
// UART transmitter with write FIFO and integrated baud divider.
//   clk, reset      : clock, asynchronous active-high reset
//   parity_enable   : append a parity bit
//   parity_type     : 0 even, 1 odd
//   two_stop_bits   : 0 one stop bit, 1 two stop bits
//   prescale        : clk cycles per bit (0 behaves as 1)
//   write_valid/data: host write into the FIFO
//   write_ready     : FIFO not full
//   fifo_count      : FIFO occupancy
//   fifo_overflow   : one-cycle pulse after a write offered while full
//   TX_out          : serial line, idle high (registered)
//   busy            : a frame is in progress (registered)
module uart_buffered_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        parity_enable,
  input  logic                        parity_type,
  input  logic                        two_stop_bits,
  input  logic [PRESCALE_WIDTH-1:0]   prescale,
  input  logic                        write_valid,
  input  logic [DATA_WIDTH-1:0]       write_data,
  output logic                        write_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_overflow,
  output logic                        TX_out,
  output logic                        busy
);

  localparam int PW    = PRESCALE_WIDTH;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             r_state, w_state_next;
  logic [PW-1:0]         r_div, w_div_next;
  logic [PW-1:0]         r_p;
  logic [PW-1:0]         w_p_in;
  logic [BIT_W-1:0]      r_bit, w_bit_next, w_bit_inc;
  logic                  r_tx, w_tx_next;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en, r_par_type, r_two_stop;
  logic                  r_overflow;
  logic                  w_pop;
  logic                  w_tick;
  logic                  w_parity;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_ready;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (write_valid),
    .i_wr_data  (write_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_count    (fifo_count),
    .o_not_full (w_ready)
  );

  assign w_p_in    = (prescale == '0) ? PW'(1) : prescale;
  assign w_tick    = (r_div == '0);
  assign w_bit_inc = r_bit + 1'b1;
  assign w_parity  = (^r_data) ^ r_par_type;

  assign write_ready   = w_ready;
  assign fifo_overflow = r_overflow;
  assign TX_out        = r_tx;
  assign busy          = r_busy;

  // Next-state logic also computes the next line level, so TX_out is a
  // flop output and never glitches. The divider is reloaded on every state
  // (or stop-bit) entry; a new frame uses the live prescale because the
  // latched copy only updates on that same edge.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (fifo_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_div_next   = w_p_in - PW'(1);
          w_tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next = ST_DATA;
          w_bit_next   = '0;
          w_div_next   = r_p - PW'(1);
          w_tx_next    = r_data[0];
        end else begin
          w_div_next = r_div - PW'(1);
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_div_next = r_p - PW'(1);
          if (r_bit == LAST_BIT) begin
            w_bit_next = '0;
            if (r_par_en) begin
              w_state_next = ST_PARITY;
              w_tx_next    = w_parity;
            end else begin
              w_state_next = ST_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_next = w_bit_inc;
            w_tx_next  = r_data[w_bit_inc];
          end
        end else begin
          w_div_next = r_div - PW'(1);
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next = ST_STOP;
          w_bit_next   = '0;
          w_div_next   = r_p - PW'(1);
          w_tx_next    = 1'b1;
        end else begin
          w_div_next = r_div - PW'(1);
        end
      end
      ST_STOP: begin
        // r_bit counts stop bits here.
        if (w_tick) begin
          if (r_two_stop && (r_bit == '0)) begin
            w_bit_next = BIT_W'(1);
            w_div_next = r_p - PW'(1);
          end else if (fifo_count != '0) begin
            // Back-to-back frame: no idle bit in between.
            w_pop        = 1'b1;
            w_state_next = ST_START;
            w_div_next   = w_p_in - PW'(1);
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_div_next   = '0;
            w_bit_next   = '0;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_div_next = r_div - PW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_div_next   = '0;
        w_bit_next   = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_two_stop <= 1'b0;
      r_p        <= PW'(1);
    end else begin
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_bit      <= w_bit_next;
      r_tx       <= w_tx_next;
      r_busy     <= (w_state_next != ST_IDLE);
      r_overflow <= write_valid && !w_ready;
      // Frame configuration is frozen at the pop.
      if (w_pop) begin
        r_data     <= w_fifo_data;
        r_par_en   <= parity_enable;
        r_par_type <= parity_type;
        r_two_stop <= two_stop_bits;
        r_p        <= w_p_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Self-checking bench for uart_buffered_transmitter (DATA_WIDTH=8,
// FIFO_DEPTH=4). The line is recorded cycle by cycle and compared frame by
// frame against waveforms built from the frame rules (start, LSB-first data,
// optional parity, one or two stops, each bit held max(prescale,1) cycles).
module tb_uart_buffered_transmitter;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          parity_enable, parity_type, two_stop_bits;
  logic [PW-1:0] prescale;
  logic          write_valid;
  logic [DW-1:0] write_data;
  logic          write_ready;
  logic [2:0]    fifo_count;
  logic          fifo_overflow;
  logic          TX_out;
  logic          busy;

  uart_buffered_transmitter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .two_stop_bits(two_stop_bits), .prescale(prescale),
    .write_valid(write_valid), .write_data(write_data),
    .write_ready(write_ready), .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow), .TX_out(TX_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] d;
    bit         pe;
    bit         pt;
    bit         ts;
    int         ps;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] wq[$];
  logic       tr_tx   [0:1023];
  logic       tr_busy [0:1023];
  logic [2:0] tr_cnt  [0:1023];
  int vectors = 0;
  int errors  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected line waveform of one frame, one vector bit per clk cycle.
  function automatic void model_frame(input frame_t f, output logic [511:0] v, output int len);
    bit b[0:12];
    int n, ones, p, idx;
    p = (f.ps < 1) ? 1 : f.ps;
    n = 0; ones = 0; idx = 0; v = '0;
    b[n] = 1'b0; n = n + 1;
    for (int i = 0; i < DW; i++) begin
      b[n] = f.d[i]; n = n + 1;
      ones = ones + int'(f.d[i]);
    end
    if (f.pe) begin b[n] = ((ones % 2) == 1) ^ f.pt; n = n + 1; end
    b[n] = 1'b1; n = n + 1;
    if (f.ts) begin b[n] = 1'b1; n = n + 1; end
    for (int j = 0; j < n; j++)
      for (int k = 0; k < p; k++) begin
        v[idx] = b[j]; idx = idx + 1;
      end
    len = idx;
  endfunction

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      tr_tx[i] = TX_out; tr_busy[i] = busy; tr_cnt[i] = fifo_count;
      tick();
    end
  endtask

  // Sample 0 is the idle cycle after the first accepted write; frames are
  // expected back to back from sample 1, then idle again.
  task automatic check_trace(input string tag);
    logic [511:0] vexp, vgot;
    int len, pos, bc;
    pos = 1;
    chk({tag, "_idle_before_tx"}, 512'(tr_tx[0]), 512'(1));
    chk({tag, "_idle_before_busy"}, 512'(tr_busy[0]), 512'(0));
    foreach (exp_q[k]) begin
      model_frame(exp_q[k], vexp, len);
      vgot = '0; bc = 0;
      for (int i = 0; i < len; i++) begin
        vgot[i] = tr_tx[pos + i];
        bc = bc + int'(tr_busy[pos + i]);
      end
      chk($sformatf("%s_frame%0d_line", tag, k), vgot, vexp);
      chk($sformatf("%s_frame%0d_busy_cycles", tag, k), 512'(bc), 512'(len));
      pos = pos + len;
    end
    chk({tag, "_idle_after_tx"}, 512'(tr_tx[pos]), 512'(1));
    chk({tag, "_idle_after_busy"}, 512'(tr_busy[pos]), 512'(0));
    exp_q.delete();
  endtask

  task automatic write_word(input logic [7:0] d);
    write_valid = 1'b1; write_data = d;
    tick();
    write_valid = 1'b0;
  endtask

  // Queue all words of wq back to back under the current configuration.
  task automatic run_batch(input string tag);
    int total;
    total = 0;
    foreach (wq[i]) begin
      exp_q.push_back('{d: {1'b0, wq[i]}, pe: parity_enable, pt: parity_type,
                        ts: two_stop_bits, ps: int'(prescale)});
      total = total + frame_cycles(DW, parity_enable, two_stop_bits, int'(prescale));
    end
    write_word(wq[0]);
    fork
      record(total + 4);
      begin
        for (int i = 1; i < wq.size(); i++) write_word(wq[i]);
      end
    join
    check_trace(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ow [0:4];
    int lows, bhigh;

    reset = 1'b1; parity_enable = 1'b0; parity_type = 1'b0; two_stop_bits = 1'b0;
    prescale = 6'd1; write_valid = 1'b0; write_data = '0;
    repeat (3) tick();
    chk("reset_tx", 512'(TX_out), 512'(1));
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_count", 512'(fifo_count), 512'(0));
    chk("reset_ready", 512'(write_ready), 512'(1));
    chk("reset_overflow", 512'(fifo_overflow), 512'(0));
    reset = 1'b0;
    repeat (2) tick();

    // Even parity, one stop, P=4, 0xA5: 44-cycle frame.
    parity_enable = 1'b1; parity_type = PARITY_EVEN; two_stop_bits = 1'b0; prescale = 6'd4;
    wq = '{8'hA5};
    run_batch("t1_a5_even");
    tick();

    // Odd parity, two stops, P=3, 0x00: 36-cycle frame.
    parity_type = PARITY_ODD; two_stop_bits = 1'b1; prescale = 6'd3;
    wq = '{8'h00};
    run_batch("t2_odd_2stop");
    tick();

    // Three contiguous frames, no parity, P=2.
    parity_enable = 1'b0; parity_type = PARITY_EVEN; two_stop_bits = 1'b0; prescale = 6'd2;
    wq = '{8'h11, 8'h22, 8'h33};
    run_batch("t3_burst");
    chk("t3_count_end_f1", 512'(tr_cnt[20]), 512'(2));
    chk("t3_count_start_f2", 512'(tr_cnt[21]), 512'(1));
    chk("t3_count_end_f2", 512'(tr_cnt[40]), 512'(1));
    chk("t3_count_start_f3", 512'(tr_cnt[41]), 512'(0));
    tick();

    // Fill the FIFO while 0x55 is on the line; the fifth write overflows.
    for (int k = 0; k < 5; k++) ow[k] = 8'($urandom);
    exp_q.push_back('{d: 9'h055, pe: 1'b0, pt: 1'b0, ts: 1'b0, ps: 2});
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{d: {1'b0, ow[k]}, pe: 1'b0, pt: 1'b0, ts: 1'b0, ps: 2});
    write_word(8'h55);
    fork
      record(104);
      begin
        tick();
        for (int k = 0; k < 5; k++) begin
          write_valid = 1'b1; write_data = ow[k];
          tick();
          if (k == 3) begin
            chk("t4_count_full", 512'(fifo_count), 512'(4));
            chk("t4_ready_low", 512'(write_ready), 512'(0));
            chk("t4_no_overflow_yet", 512'(fifo_overflow), 512'(0));
          end
          if (k == 4) begin
            chk("t4_overflow_pulse", 512'(fifo_overflow), 512'(1));
            chk("t4_count_held", 512'(fifo_count), 512'(4));
          end
        end
        write_valid = 1'b0;
        tick();
        chk("t4_overflow_cleared", 512'(fifo_overflow), 512'(0));
      end
    join
    check_trace("t4_overflow");
    tick();

    // prescale=0 acts as 1; raising it mid-frame only affects the next frame.
    prescale = 6'd0;
    ow[0] = 8'($urandom); ow[1] = 8'($urandom);
    exp_q.push_back('{d: {1'b0, ow[0]}, pe: 1'b0, pt: 1'b0, ts: 1'b0, ps: 0});
    exp_q.push_back('{d: {1'b0, ow[1]}, pe: 1'b0, pt: 1'b0, ts: 1'b0, ps: 8});
    write_word(ow[0]);
    fork
      record(1 + 10 + 80 + 4);
      begin
        write_word(ow[1]);
        repeat (2) tick();
        prescale = 6'd8;
      end
    join
    check_trace("t5_prescale");
    tick();

    // Asynchronous reset mid-DATA with two words still queued.
    prescale = 6'd4;
    for (int k = 0; k < 3; k++) begin
      write_valid = 1'b1; write_data = 8'($urandom);
      tick();
    end
    write_valid = 1'b0;
    repeat (7) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_async_tx", 512'(TX_out), 512'(1));
    chk("t6_async_busy", 512'(busy), 512'(0));
    chk("t6_async_count", 512'(fifo_count), 512'(0));
    chk("t6_async_ready", 512'(write_ready), 512'(1));
    repeat (2) tick();
    reset = 1'b0;
    record(30);
    lows = 0; bhigh = 0;
    for (int i = 0; i < 30; i++) begin
      lows = lows + int'(!tr_tx[i]);
      bhigh = bhigh + int'(tr_busy[i]);
    end
    chk("t6_quiet_tx_low_cycles", 512'(lows), 512'(0));
    chk("t6_quiet_busy_cycles", 512'(bhigh), 512'(0));
    wq = '{8'($urandom)};
    run_batch("t6_post_reset");
    tick();

    // Randomised batches of 1..3 words under random configuration.
    for (int r = 0; r < 6; r++) begin
      int n;
      parity_enable = 1'($urandom); parity_type = 1'($urandom);
      two_stop_bits = 1'($urandom); prescale = 6'($urandom_range(0, 5));
      n = $urandom_range(1, 3);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      run_batch($sformatf("rand%0d", r));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
